// File: rtl/stream_dup_map_n.sv
// stream_dup_map_n
//   Duplicates one valid/ready input stream onto CHANNELS output streams.
//   Each copy is mapped per channel at push time and queued in a
//   DEPTH-entry FIFO, so consumers can stall independently.
//   LOSSY=0: the input stalls while any channel FIFO is full.
//   LOSSY=1: the input never stalls; a full channel drops the word and
//   bumps its saturating drop counter.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   sIn         input data (WIDTH)
//   sIn_valid   input word present
//   sIn_ready   block accepts sIn this cycle
//   op          per-channel map select, channel k at [2k+1:2k]
//               (0 identity, 1 x+1, 2 -x, 3 x<<1)
//   sOut        output data, channel k at [WIDTH*k +: WIDTH]
//   sOut_valid  per-channel output valid
//   sOut_ready  per-channel consumer ready
//   drops       per-channel drop counts, channel k at [CW*k +: CW]
module stream_dup_map_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  parameter int LOSSY    = 0,
  parameter int CW       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          sIn,
  input  logic                      sIn_valid,
  output logic                      sIn_ready,
  input  logic [2*CHANNELS-1:0]     op,
  output logic [WIDTH*CHANNELS-1:0] sOut,
  output logic [CHANNELS-1:0]       sOut_valid,
  input  logic [CHANNELS-1:0]       sOut_ready,
  output logic [CW*CHANNELS-1:0]    drops
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [CHANNELS-1:0] full;
  logic                acc;

  // Readiness only looks at registered counts, so there is no path from
  // sOut_ready to sIn_ready; space freed by a pop shows up next cycle.
  if (LOSSY == 0) begin : g_ready_bp
    assign sIn_ready = ~rst & ~(|full);
  end else begin : g_ready_lossy
    assign sIn_ready = ~rst;
  end

  assign acc = sIn_valid & sIn_ready;

  function automatic logic [WIDTH-1:0] map_op(input logic [1:0] sel,
                                              input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    case (sel)
      2'd0: r = x;
      2'd1: r = x + WIDTH'(1);
      2'd2: r = '0 - x;
      2'd3: r = x << 1;
      default: r = x;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full[k] = (count == CNT_FULL);
    // In lossless mode acc already implies no channel is full; in lossy
    // mode a full channel turns the push into a drop even if it pops now.
    assign push = acc & ~full[k];
    assign sOut_valid[k] = ~rst & (count != '0);
    assign pop  = sOut_valid[k] & sOut_ready[k];
    assign sOut[WIDTH*k +: WIDTH] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= map_op(op[2*k +: 2], sIn);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end

    if (LOSSY != 0) begin : g_drops
      logic [CW-1:0] drop_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          drop_cnt <= '0;
        end else if (acc && full[k] && (drop_cnt != '1)) begin
          drop_cnt <= drop_cnt + CW'(1);
        end
      end
      assign drops[CW*k +: CW] = drop_cnt;
    end else begin : g_no_drops
      assign drops[CW*k +: CW] = '0;
    end
  end

endmodule

// File: tb/tb_stream_dup_map_n.sv
// tb_stream_dup_map_n
//   Directed bench for stream_dup_map_n. Three instances share stimulus:
//   a lossless one, a lossy one with CW=8 and a lossy one with CW=3.
module tb_stream_dup_map_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sin = '0;
  logic       vld = 1'b0;
  logic [3:0] op  = '0;
  logic [1:0] rdy = 2'b11;

  logic        a_rdy, b_rdy, c_rdy;
  logic [15:0] a_out, b_out, c_out;
  logic [1:0]  a_vld, b_vld, c_vld;
  logic [15:0] a_drops, b_drops;
  logic [5:0]  c_drops;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(4), .LOSSY(0), .CW(8)) u_a (
    .clk(clk), .rst(rst), .sIn(sin), .sIn_valid(vld), .sIn_ready(a_rdy),
    .op(op), .sOut(a_out), .sOut_valid(a_vld), .sOut_ready(rdy), .drops(a_drops)
  );

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(4), .LOSSY(1), .CW(8)) u_b (
    .clk(clk), .rst(rst), .sIn(sin), .sIn_valid(vld), .sIn_ready(b_rdy),
    .op(op), .sOut(b_out), .sOut_valid(b_vld), .sOut_ready(rdy), .drops(b_drops)
  );

  stream_dup_map_n #(.WIDTH(8), .CHANNELS(2), .DEPTH(4), .LOSSY(1), .CW(3)) u_c (
    .clk(clk), .rst(rst), .sIn(sin), .sIn_valid(vld), .sIn_ready(c_rdy),
    .op(op), .sOut(c_out), .sOut_valid(c_vld), .sOut_ready(rdy), .drops(c_drops)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Wrap-around table: op[1:0] drives channel 0, op[3:2] channel 1.
  logic [7:0] w_in  [3] = '{8'hFF, 8'h80, 8'h01};
  logic [3:0] w_op  [3] = '{4'b1101, 4'b1011, 4'b1110};
  logic [7:0] w_ch0 [3] = '{8'h00, 8'h00, 8'hFF};
  logic [7:0] w_ch1 [3] = '{8'hFE, 8'h80, 8'h02};
  logic [7:0] pp_exp [3] = '{8'd21, 8'd22, 8'd24};

  initial begin
    // Reset
    step; step;
    chk("rst_ready", 32'(a_rdy), 0);
    chk("rst_valid", 32'(a_vld), 0);
    chk("rst_drops", 32'(b_drops), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(a_rdy), 1);
    chk("post_rst_valid", 32'(a_vld), 0);

    // Streaming, ch0 op=1, ch1 op=0
    op = 4'b0001;
    vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sin = 8'(i);
      chk("stream_ready", 32'(a_rdy), 1);
      step;
      chk("stream_ch0", 32'(a_out[7:0]), 32'(i + 1));
      chk("stream_ch1", 32'(a_out[15:8]), 32'(i));
      chk("stream_vld", 32'(a_vld), 2'b11);
    end

    // Wrap-around ops
    for (int j = 0; j < 3; j++) begin
      sin = w_in[j];
      op  = w_op[j];
      step;
      chk("wrap_ch0", 32'(a_out[7:0]), 32'(w_ch0[j]));
      chk("wrap_ch1", 32'(a_out[15:8]), 32'(w_ch1[j]));
    end
    vld = 1'b0;
    step;
    chk("idle_vld", 32'(a_vld), 0);

    // Lossless back-pressure with channel 1 stalled
    op  = 4'b0000;
    rdy = 2'b01;
    vld = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      sin = 8'(10 + i);
      chk("bp_ready", 32'(a_rdy), 1);
      step;
      chk("bp_ch0", 32'(a_out[7:0]), 32'(10 + i));
      chk("bp_ch0_vld", 32'(a_vld[0]), 1);
    end
    sin = 8'd14;
    chk("bp_full", 32'(a_rdy), 0);
    step;
    chk("bp_ch0_idle", 32'(a_vld[0]), 0);
    chk("bp_ch1_head", 32'(a_out[15:8]), 10);
    chk("bp_full_hold", 32'(a_rdy), 0);
    rdy = 2'b11;
    #1;
    chk("bp_no_comb_path", 32'(a_rdy), 0);
    step;
    rdy = 2'b01;
    #1;
    chk("bp_reopen", 32'(a_rdy), 1);
    chk("bp_ch1_next", 32'(a_out[15:8]), 11);
    step;
    chk("bp_ch0_14", 32'(a_out[7:0]), 14);
    chk("bp_ch0_14_vld", 32'(a_vld[0]), 1);
    chk("bp_full_again", 32'(a_rdy), 0);
    vld = 1'b0;
    rdy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain", 32'(a_out[15:8]), 32'(11 + i));
      chk("bp_drain_vld", 32'(a_vld[1]), 1);
      step;
    end
    chk("bp_drained", 32'(a_vld), 0);

    // Push and pop on a FIFO holding 3, with op changed while queued
    rdy = 2'b00;
    vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sin = 8'(20 + i);
      step;
    end
    chk("pp_vld", 32'(a_vld), 2'b11);
    chk("pp_head", 32'(a_out[7:0]), 20);
    op  = 4'b0101;
    sin = 8'd23;
    rdy = 2'b11;
    step;
    vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pp_ch0", 32'(a_out[7:0]), 32'(pp_exp[i]));
      chk("pp_ch1", 32'(a_out[15:8]), 32'(pp_exp[i]));
      step;
    end
    chk("pp_count3", 32'(a_vld), 0);

    // Reset with words queued
    op  = 4'b0000;
    rdy = 2'b00;
    vld = 1'b1;
    sin = 8'd30;
    step;
    sin = 8'd31;
    step;
    vld = 1'b0;
    chk("mid_queued", 32'(a_vld), 2'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(a_vld), 0);
    chk("mid_rst_ready", 32'(a_rdy), 0);
    step;
    rst = 1'b0;
    #1;
    chk("mid_a_vld", 32'(a_vld), 0);
    chk("mid_b_vld", 32'(b_vld), 0);
    chk("mid_b_drops", 32'(b_drops), 0);
    chk("mid_ready", 32'(a_rdy), 1);
    vld = 1'b1;
    sin = 8'd40;
    rdy = 2'b11;
    step;
    vld = 1'b0;
    chk("mid_first_ch0", 32'(a_out[7:0]), 40);
    chk("mid_first_ch1", 32'(a_out[15:8]), 40);
    chk("mid_first_vld", 32'(a_vld), 2'b11);
    step;
    chk("mid_empty", 32'(a_vld), 0);

    // Lossy mode with channel 1 stalled
    rst = 1'b1;
    step;
    rst = 1'b0;
    rdy = 2'b01;
    vld = 1'b1;
    #1;
    for (int i = 0; i < 14; i++) begin
      int e;
      sin = 8'(i);
      chk("ly_b_ready", 32'(b_rdy), 1);
      chk("ly_c_ready", 32'(c_rdy), 1);
      step;
      e = (i >= 4) ? i - 3 : 0;
      chk("ly_ch0", 32'(b_out[7:0]), 32'(i));
      chk("ly_b_drops1", 32'(b_drops[15:8]), 32'(e));
      chk("ly_c_drops1", 32'(c_drops[5:3]), 32'((e > 7) ? 7 : e));
      chk("ly_b_drops0", 32'(b_drops[7:0]), 0);
    end
    chk("ly_a_drops", 32'(a_drops), 0);
    vld = 1'b0;
    rdy = 2'b10;
    for (int i = 0; i < 4; i++) begin
      chk("ly_b_ch1", 32'(b_out[15:8]), 32'(i));
      chk("ly_c_ch1", 32'(c_out[15:8]), 32'(i));
      chk("ly_c_vld1", 32'(c_vld[1]), 1);
      step;
    end
    chk("ly_b_empty", 32'(b_vld[1]), 0);
    chk("ly_c_sat", 32'(c_drops[5:3]), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_dup_map_n.md
# stream_dup_map_n

Parametrised stream fan-out: one input stream is duplicated onto CHANNELS output streams, and a per-channel map operation is applied to each copy. Each channel has its own DEPTH-entry FIFO, so consumers can stall independently until a FIFO fills. It generalises the two-way duplicate/map stream stage produced by the compiler. It sits between a stream producer and several compiled consumer blocks, using the standard valid/ready stream handshake from primitives.v.

## Interface
- WIDTH, 8: data width in bits (the intN of the design).
- CHANNELS, 2: number of output streams (≥1).
- DEPTH, 4: FIFO entries per channel; a power of two, ≥2.
- LOSSY, 0: 0 applies back-pressure from the slowest channel; 1 means the input never stalls and a full channel drops the word.
- CW, 8: width of each drop counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sIn  in  WIDTH  input data.
- sIn_valid  in  1  input word present.
- sIn_ready  out  1  block accepts sIn this cycle.
- op  in  2*CHANNELS  per-channel map select; channel k uses bits [2k+1:2k].
- sOut  out  WIDTH*CHANNELS  output data; channel k uses bits [WIDTH*k +: WIDTH].
- sOut_valid  out  CHANNELS  per-channel output valid.
- sOut_ready  in  CHANNELS  per-channel consumer ready.
- drops  out  CW*CHANNELS  per-channel saturating drop count (LOSSY=1 only; tied to 0 otherwise).

## Operation
- Map ops (modulo 2^WIDTH):
  - 0 = identity.
  - 1 = x+1.
  - 2 = -x (two's complement).
  - 3 = x<<1.
- The map is applied at push time using op sampled in the accept cycle. A later change to op does not affect words already queued.
- Accept: `acc = sIn_valid & sIn_ready`.
- LOSSY=0:
  - sIn_ready = ~rst & (no channel FIFO full), evaluated on registered counts.
  - On acc, every channel pushes its mapped word.
- LOSSY=1:
  - sIn_ready = ~rst.
  - On acc, each non-full channel pushes.
  - Each full channel discards the word and increments its drops[k], saturating at 2^CW−1.
- Per-channel FIFO:
  - Storage is a register array with rd_ptr, wr_ptr (log2 DEPTH bits, wrapping) and count (0..DEPTH).
  - sOut_valid[k] = (count_k != 0).
  - sOut[k] = mem_k[rd_ptr_k].
  - pop_k = sOut_valid[k] & sOut_ready[k].
- Count update: push&~pop → +1; pop&~push → −1; push&pop → unchanged, with both pointers advancing.
- A push into a full FIFO is impossible in mode 0. In mode 1 it is converted into a drop, even if that channel pops in the same cycle.
- sIn_ready has no combinational path from sOut_ready. Freed space becomes visible the cycle after the pop.
- Reset:
  - Counts, pointers and drops clear to 0.
  - sOut_valid = 0 and sIn_ready = 0 while rst is high.
  - Memory contents are don't-care.
  - A reset mid-operation discards all queued words. Words in flight are lost without error.

## Timing
- Latency: a word accepted at edge t is valid on sOut at cycle t+1 (one register stage).
- Throughput: one word per cycle per channel when all consumers are ready.
- Each channel delivers words strictly in accept order.
- Channels are mutually independent except through back-pressure on the shared input (mode 0).
- sOut/sOut_valid hold stable while valid & ~ready.
- The cycle after rst falls: sIn_ready = 1 and all sOut_valid = 0.
- drops update one cycle after the dropping accept.

## Test plan
- Reset, CHANNELS=2, op={1,0}, all ready, sIn = 0,1,2,… each cycle.
  - Channel 0 outputs 1,2,3,…; channel 1 outputs 0,1,2,…, each one cycle after accept.
  - sIn_ready stays 1 throughout.
- Wrap-around ops, WIDTH=8.
  - sIn=0xFF with op=1 → 0x00.
  - sIn=0x80 with op=3 → 0x00.
  - sIn=0x01 with op=2 → 0xFF.
- LOSSY=0, DEPTH=4, hold sOut_ready[1]=0 while streaming.
  - After 4 accepts sIn_ready drops to 0.
  - Channel 0 drains 4 words, then idles.
  - Raising ready[1] for one cycle re-asserts sIn_ready on the following cycle.
  - No word is lost or duplicated on either channel.
- LOSSY=1, DEPTH=4, sOut_ready[1]=0 for 10 accepts of 0..9.
  - Channel 1 holds 0..3 and drops[1] = 6.
  - Channel 0 delivers 0..9.
  - With CW=3, 10 drops saturate the counter at 7.
- Simultaneous push and pop on a FIFO holding 3 entries: count stays 3 and order is preserved. Change op while words are queued: queued words keep their old mapping.
- Assert rst for 1 cycle with words queued in both channels.
  - All sOut_valid and drops read 0 on the next cycle; the next accepted word is the first output.
